fp_regfile_sb: RTL
==================

Name: fp_regfile_sb

Overview:
- Parametrised floating-point register file for the F/D datapath: FLEN-wide, NREGS entries, three combinational read ports (rs1/rs2/rs3 for FMA).
- Two write ports: wr0 for the main pipeline writeback, wr1 for the long-latency unit (divide/sqrt) writeback.
- Adds NaN-boxing of single-precision values, a per-register pending scoreboard for long-latency results, and an FS-dirty status flag for mstatus.
- Sits between decode/issue and the FP execute units.

Parameters:
- FLEN, 64, register width; legal values 32 or 64.
- NREGS, 32, number of FP registers; power of two, 2..32.
- AW, $clog2(NREGS), address width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_addr, rs2_addr, rs3_addr  in  AW each  read addresses.
- rs1_sp, rs2_sp, rs3_sp  in  1 each  1 = read as single-precision (unbox check).
- rs1_data, rs2_data, rs3_data  out  FLEN each  read data.
- rs1_busy, rs2_busy, rs3_busy  out  1 each  addressed register has a pending long-latency write.
- wr0_en  in  1  main writeback enable.
- wr0_addr  in  AW  main writeback address.
- wr0_data  in  FLEN  main writeback data.
- wr0_sp  in  1  main writeback is single-precision; box on write.
- wr1_en  in  1  long-latency writeback enable.
- wr1_addr  in  AW  long-latency writeback address.
- wr1_data  in  FLEN  long-latency writeback data.
- wr1_sp  in  1  long-latency writeback is single-precision; box on write.
- iss_en  in  1  long-latency op issued; marks its destination pending.
- iss_addr  in  AW  destination of the issued long-latency op.
- fs_dirty  out  1  set by any write; models mstatus.FS == Dirty.
- fs_clear  in  1  clears fs_dirty (CSR write of FS).

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, fs_dirty = 0. Read outputs therefore show 0 and busy outputs 0 while reset is held.
- Reset mid-operation discards all pending state. A wr1 arriving after reset has no busy bit to clear, and the write itself still occurs.
- Write boxing:
  - FLEN=64 and wrN_sp=1: stored value = {32'hFFFF_FFFF, data[31:0]}.
  - FLEN=64 and wrN_sp=0: full data stored.
  - FLEN=32: sp inputs are ignored and data is stored as-is.
- Dual write to the same address in one cycle: wr0 data is stored (younger instruction wins). wr1 still clears that busy bit.
- Writes to different addresses in the same cycle both occur.
- Read unboxing (FLEN=64, rsN_sp=1):
  - If upper 32 bits of the stored entry are all ones, output the entry unchanged.
  - Otherwise output {32'hFFFF_FFFF, 32'h7FC0_0000} (canonical NaN).
  - rsN_sp=0, or FLEN=32: output the raw entry.
- Reads are combinational. Without bypass, a read in the same cycle as a write to that address returns the old value.
- Scoreboard:
  - busy[iss_addr] is set on the edge after iss_en.
  - busy[wr1_addr] is cleared on the edge after wr1_en.
  - iss_en and wr1_en to the same address in one cycle: set wins (the new issue is pending).
  - wr0 does not affect busy.
  - rsN_busy = busy[rsN_addr], combinational.
- fs_dirty:
  - Set on the edge after any wr0_en or wr1_en.
  - Cleared on the edge after fs_clear.
  - Write and fs_clear in the same cycle: set wins.
- Out-of-range addresses (NREGS < 32 with wider decode upstream) cannot occur, because AW bounds them.

Optional Feature:
- Macro FPRF_BYPASS_EN.
- When defined, the read ports forward same-cycle write data:
  - If wr0_en and wr0_addr == rsN_addr, rsN_data is the boxed wr0 data, then unboxed per rsN_sp.
  - Else, if wr1_en matches, the same applies with wr1 data.
  - wr0 has priority over wr1.
  - rsN_busy is forced to 0 when wr1 matches that port in the same cycle, unless iss_en also targets that address.
- When undefined: reads reflect register contents only, busy reflects registered state only, and there are no forwarding muxes.

Test Plan:
- Reset check: assert rst mid-run after writes and issues -> all rsN_data = 0, all rsN_busy = 0, fs_dirty = 0 immediately, without waiting for a clock edge.
- NaN-boxing (FLEN=64):
  - Write f3 with wr0_sp=1, data 0x0000_0000_3F80_0000 -> raw read 0xFFFF_FFFF_3F80_0000; sp read the same.
  - Write f3 with wr0_sp=0, data 0x4000_0000_0000_0000 -> sp read 0xFFFF_FFFF_7FC0_0000.
- Scoreboard: iss_en to f5, then a read of f5 -> busy=1. Next cycle, iss_en to f5 plus wr1_en to f5 -> busy stays 1. Following cycle, wr1_en to f5 alone -> busy=0.
- Write collision: wr0 to f7 = 0x11 and wr1 to f7 = 0x22 in the same cycle -> f7 reads 0x11 and busy[7] = 0.
- Bypass (macro on): wr0 to f9 = 0xABCD while rs2_addr=9 -> rs2_data = 0xABCD in the same cycle. With the macro off, rs2_data shows the old value until the next cycle.
- fs_dirty: a write sets it. fs_clear with no write clears it. fs_clear together with a write leaves it at 1. NREGS=8 run: f7 write/read works, and address wraps within 3 bits.

Source files
------------

// File: rtl/fp_regfile_sb.sv
// Floating-point register file with NaN-boxing, long-latency pending scoreboard and FS-dirty flag.
// Optional same-cycle write-to-read forwarding is enabled by defining FPRF_BYPASS_EN.
module fp_regfile_sb #(
    parameter int FLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rs3_addr,
    input  logic            rs1_sp,
    input  logic            rs2_sp,
    input  logic            rs3_sp,
    output logic [FLEN-1:0] rs1_data,
    output logic [FLEN-1:0] rs2_data,
    output logic [FLEN-1:0] rs3_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rs3_busy,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [FLEN-1:0] wr0_data,
    input  logic            wr0_sp,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [FLEN-1:0] wr1_data,
    input  logic            wr1_sp,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            fs_dirty,
    input  logic            fs_clear
);

    localparam int NP = 3;

    logic [FLEN-1:0]  regs_q [NREGS];
    logic [FLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             fs_dirty_q;
    logic             fs_dirty_d;

    logic [AW-1:0]    rd_addr  [NP];
    logic             rd_sp    [NP];
    logic [FLEN-1:0]  rd_entry [NP];
    logic [FLEN-1:0]  rd_data  [NP];
    logic             rd_busy  [NP];

    // Single-precision values are stored with all-ones above bit 31; a no-op when FLEN is 32.
    function automatic logic [FLEN-1:0] box(input logic [FLEN-1:0] d, input logic sp);
        logic [FLEN-1:0] r;
        r = d;
        if (sp) begin
            for (int i = 32; i < FLEN; i++) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [FLEN-1:0] unbox(input logic [FLEN-1:0] e, input logic sp);
        logic            upper_ones;
        logic [FLEN-1:0] r;
        upper_ones = 1'b1;
        for (int i = 32; i < FLEN; i++) begin
            upper_ones = upper_ones & e[i];
        end
        r = e;
        if ((FLEN > 32) && sp && !upper_ones) begin
            r       = '1;
            r[31:0] = 32'h7FC0_0000;
        end
        return r;
    endfunction

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;
    assign rd_addr[2] = rs3_addr;
    assign rd_sp[0]   = rs1_sp;
    assign rd_sp[1]   = rs2_sp;
    assign rd_sp[2]   = rs3_sp;

    // wr0 is applied last so the younger instruction wins an address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr1_en) begin
            regs_d[wr1_addr] = box(wr1_data, wr1_sp);
        end
        if (wr0_en) begin
            regs_d[wr0_addr] = box(wr0_data, wr0_sp);
        end
    end

    // A fresh issue outranks a completing write to the same destination.
    always_comb begin
        busy_d = busy_q;
        if (wr1_en) begin
            busy_d[wr1_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        fs_dirty_d = fs_dirty_q;
        if (fs_clear) begin
            fs_dirty_d = 1'b0;
        end
        if (wr0_en || wr1_en) begin
            fs_dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            fs_dirty_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            fs_dirty_q <= fs_dirty_d;
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            rd_entry[p] = regs_q[rd_addr[p]];
            rd_busy[p]  = busy_q[rd_addr[p]];
`ifdef FPRF_BYPASS_EN
            if (wr0_en && (wr0_addr == rd_addr[p])) begin
                rd_entry[p] = box(wr0_data, wr0_sp);
            end else if (wr1_en && (wr1_addr == rd_addr[p])) begin
                rd_entry[p] = box(wr1_data, wr1_sp);
            end
            if (wr1_en && (wr1_addr == rd_addr[p]) && !(iss_en && (iss_addr == rd_addr[p]))) begin
                rd_busy[p] = 1'b0;
            end
`endif
            rd_data[p] = unbox(rd_entry[p], rd_sp[p]);
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs3_data = rd_data[2];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];
    assign rs3_busy = rd_busy[2];
    assign fs_dirty = fs_dirty_q;

endmodule
